// File: rtl/rr_grant_scheduler_if.sv
// Requester/scheduler bundle for the 4-way round-robin scheduler.
// gnt_valid is the only qualifier: gnt/gnt_idx name the owner only while it is 1;
// there is no back-pressure, the owner ends a grant by pulsing done or dropping req.
interface rr_grant_scheduler_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       state_dbg;
  logic [1:0] ptr_dbg;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout, state_dbg, ptr_dbg
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout, state_dbg, ptr_dbg
  );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner of one shared resource among four requesters, with a
// hold timeout and a one-cycle bubble between consecutive grants.
module rr_grant_scheduler #(
  parameter int MAX_HOLD = 8
) (
  input logic                  clk,
  input logic                  rst,
  rr_grant_scheduler_if.slave  bus
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_idx_q, gnt_idx_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;

  logic [1:0]    pick_idx;
  logic          pick_found;
  logic [1:0]    cand;
  logic          owner_done;
  logic          owner_gone;
  logic          hold_expired;

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_done   = bus.done;
  assign owner_gone   = !bus.req[gnt_idx_q];
  assign hold_expired = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      GRANT: begin
        if (owner_done || owner_gone || hold_expired) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 2'd1;
          // done and withdrawal take precedence over the forced release.
          timeout_d   = !owner_done && !owner_gone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  // 2x4 decoder gated by gnt_valid; fed only from registers.
  wire       s1_n;
  wire       s0_n;
  wire [3:0] gnt_w;

  not u_inv1 (s1_n, gnt_idx_q[1]);
  not u_inv0 (s0_n, gnt_idx_q[0]);
  and u_dec0 (gnt_w[0], s1_n,         s0_n,         gnt_valid_q);
  and u_dec1 (gnt_w[1], s1_n,         gnt_idx_q[0], gnt_valid_q);
  and u_dec2 (gnt_w[2], gnt_idx_q[1], s0_n,         gnt_valid_q);
  and u_dec3 (gnt_w[3], gnt_idx_q[1], gnt_idx_q[0], gnt_valid_q);

  assign bus.gnt       = gnt_w;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.state_dbg = state_q;
  assign bus.ptr_dbg   = ptr_q;

endmodule
